// File: rtl/player_animator.sv
// player_animator: per-player sprite sequencer for color_mapper.
// Turns level key requests into a sprite frame index (action) and a facing
// (direction). Animation advances once per VGA frame, detected as a rising
// edge of frame_clk resampled into the Clk domain.
//
// state | meaning
// IDLE  | standing, action 9
// WALK  | walk cycle 0..3, facing follows left/right key
// PUNCH | attack frames 4,5,6; hit on frame 5
// KICK  | attack frames 7,8; hit on frame 8
// JUMP  | jump frames 11..14, no hit
module player_animator #(
  parameter int FRAMES_PER_STEP = 6,
  parameter int START_DIR       = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_punch,
  input  logic       key_kick,
  input  logic       key_jump,
  output logic [9:0] action,
  output logic [9:0] direction,
  output logic       busy,
  output logic       hit_pulse
);

  typedef enum logic [2:0] {IDLE, WALK, PUNCH, KICK, JUMP} state_t;

  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_STEP - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          frame_clk_d;
  logic          tick;
  logic          step_done;
  logic          move;
  logic [9:0]    last_frame;

  assign tick      = frame_clk & ~frame_clk_d;
  assign step_done = (cnt == CNT_LAST);
  assign move      = key_left ^ key_right;

  // Final frame of the current attack/jump sequence.
  always_comb begin
    last_frame = 10'd9;
    case (state)
      PUNCH:   last_frame = 10'd6;
      KICK:    last_frame = 10'd7 + 10'd1;
      JUMP:    last_frame = 10'd14;
      default: last_frame = 10'd9;
    endcase
  end

  // Sequencer: state, frame index, facing, hold counter and hit strobe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      action      <= 10'd9;
      direction   <= 10'(START_DIR);
      busy        <= 1'b0;
      hit_pulse   <= 1'b0;
      cnt         <= '0;
      frame_clk_d <= 1'b0;
    end else begin
      frame_clk_d <= frame_clk;
      hit_pulse   <= 1'b0;
      if (tick) begin
        case (state)
          IDLE, WALK: begin
            if (key_punch) begin
              state  <= PUNCH;
              action <= 10'd4;
              busy   <= 1'b1;
              cnt    <= '0;
            end else if (key_kick) begin
              state  <= KICK;
              action <= 10'd7;
              busy   <= 1'b1;
              cnt    <= '0;
            end else if (key_jump) begin
              state  <= JUMP;
              action <= 10'd11;
              busy   <= 1'b1;
              cnt    <= '0;
            end else if (move) begin
              direction <= {9'd0, key_right};
              if (state == IDLE) begin
                state  <= WALK;
                action <= 10'd0;
                cnt    <= '0;
              end else if (step_done) begin
                cnt    <= '0;
                action <= (action == 10'd3) ? 10'd0 : action + 10'd1;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else begin
              state  <= IDLE;
              action <= 10'd9;
              cnt    <= '0;
            end
          end
          PUNCH, KICK, JUMP: begin
            if (!step_done) begin
              cnt <= cnt + CW'(1);
            end else begin
              cnt <= '0;
              if (action == last_frame) begin
                state  <= IDLE;
                action <= 10'd9;
                busy   <= 1'b0;
              end else begin
                action <= action + 10'd1;
                // Strike lands on the second frame of either attack.
                if ((state == PUNCH && action == 10'd4) ||
                    (state == KICK  && action == 10'd7))
                  hit_pulse <= 1'b1;
              end
            end
          end
          default: begin
            state  <= IDLE;
            action <= 10'd9;
            busy   <= 1'b0;
            cnt    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_player_animator.sv
// Directed bench for player_animator with FRAMES_PER_STEP=2, START_DIR=1.
module tb_player_animator;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       key_left, key_right, key_punch, key_kick, key_jump;
  logic [9:0] action;
  logic [9:0] direction;
  logic       busy;
  logic       hit_pulse;

  int tests = 0;
  int fails = 0;

  player_animator #(.FRAMES_PER_STEP(2), .START_DIR(1)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .key_left(key_left), .key_right(key_right), .key_punch(key_punch),
    .key_kick(key_kick), .key_jump(key_jump),
    .action(action), .direction(direction), .busy(busy), .hit_pulse(hit_pulse)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame tick, then check outputs just after it and that hit_pulse
  // has dropped one Clk later.
  task automatic step(input string tag, input logic [9:0] ea, input logic [9:0] ed,
                      input logic eb, input logic eh);
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    chk({tag, ".action"}, 32'(action), 32'(ea));
    chk({tag, ".direction"}, 32'(direction), 32'(ed));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".hit"}, 32'(hit_pulse), 32'(eh));
    @(negedge Clk);
    chk({tag, ".hit_clear"}, 32'(hit_pulse), 32'd0);
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0;
    key_left = 0; key_right = 0; key_punch = 0; key_kick = 0; key_jump = 0;

    // Reset held 3 Clk with frame_clk toggling
    @(posedge Clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("rst.action", 32'(action), 32'd9);
      chk("rst.direction", 32'(direction), 32'd1);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.hit", 32'(hit_pulse), 32'd0);
      frame_clk = ~frame_clk;
    end
    @(negedge Clk) begin Reset = 1'b0; frame_clk = 1'b0; end
    @(negedge Clk);
    step("idle", 10'd9, 10'd1, 1'b0, 1'b0);

    // Walk right for 10 ticks
    key_right = 1;
    begin
      logic [9:0] seq [10] = '{10'd0, 10'd0, 10'd1, 10'd1, 10'd2, 10'd2, 10'd3, 10'd3, 10'd0, 10'd0};
      for (int i = 0; i < 10; i++) step($sformatf("walk%0d", i), seq[i], 10'd1, 1'b0, 1'b0);
    end
    key_right = 0;
    step("walk_rel", 10'd9, 10'd1, 1'b0, 1'b0);

    // Reverse mid-walk at frame 2
    key_right = 1;
    step("rv0", 10'd0, 10'd1, 1'b0, 1'b0);
    step("rv1", 10'd0, 10'd1, 1'b0, 1'b0);
    step("rv2", 10'd1, 10'd1, 1'b0, 1'b0);
    step("rv3", 10'd1, 10'd1, 1'b0, 1'b0);
    step("rv4", 10'd2, 10'd1, 1'b0, 1'b0);
    key_right = 0; key_left = 1;
    step("rv_left", 10'd2, 10'd0, 1'b0, 1'b0);
    step("rv_left2", 10'd3, 10'd0, 1'b0, 1'b0);
    key_right = 1;
    step("both", 10'd9, 10'd0, 1'b0, 1'b0);
    key_right = 0; key_left = 0;
    step("none", 10'd9, 10'd0, 1'b0, 1'b0);

    // Punch pulsed for one tick; kick/left mid-punch ignored
    key_punch = 1;
    step("p0", 10'd4, 10'd0, 1'b1, 1'b0);
    key_punch = 0;
    step("p1", 10'd4, 10'd0, 1'b1, 1'b0);
    key_kick = 1; key_left = 1;
    step("p2", 10'd5, 10'd0, 1'b1, 1'b1);
    step("p3", 10'd5, 10'd0, 1'b1, 1'b0);
    step("p4", 10'd6, 10'd0, 1'b1, 1'b0);
    step("p5", 10'd6, 10'd0, 1'b1, 1'b0);
    step("p_end", 10'd9, 10'd0, 1'b0, 1'b0);
    key_kick = 0; key_left = 0;

    // Punch and kick together: punch wins
    key_punch = 1; key_kick = 1;
    step("pk0", 10'd4, 10'd0, 1'b1, 1'b0);
    key_punch = 0; key_kick = 0;
    step("pk1", 10'd4, 10'd0, 1'b1, 1'b0);
    step("pk2", 10'd5, 10'd0, 1'b1, 1'b1);
    step("pk3", 10'd5, 10'd0, 1'b1, 1'b0);
    step("pk4", 10'd6, 10'd0, 1'b1, 1'b0);
    step("pk5", 10'd6, 10'd0, 1'b1, 1'b0);
    step("pk_end", 10'd9, 10'd0, 1'b0, 1'b0);

    // Kick, then jump
    key_kick = 1;
    step("k0", 10'd7, 10'd0, 1'b1, 1'b0);
    key_kick = 0;
    step("k1", 10'd7, 10'd0, 1'b1, 1'b0);
    step("k2", 10'd8, 10'd0, 1'b1, 1'b1);
    step("k3", 10'd8, 10'd0, 1'b1, 1'b0);
    step("k_end", 10'd9, 10'd0, 1'b0, 1'b0);
    key_jump = 1;
    step("j0", 10'd11, 10'd0, 1'b1, 1'b0);
    key_jump = 0;
    begin
      logic [9:0] jseq [7] = '{10'd11, 10'd12, 10'd12, 10'd13, 10'd13, 10'd14, 10'd14};
      for (int i = 0; i < 7; i++) step($sformatf("j%0d", i + 1), jseq[i], 10'd0, 1'b1, 1'b0);
    end
    step("j_end", 10'd9, 10'd0, 1'b0, 1'b0);

    // Reset during jump at frame 12
    key_jump = 1;
    step("rj0", 10'd11, 10'd0, 1'b1, 1'b0);
    key_jump = 0;
    step("rj1", 10'd11, 10'd0, 1'b1, 1'b0);
    step("rj2", 10'd12, 10'd0, 1'b1, 1'b0);
    Reset = 1'b1;
    @(negedge Clk);
    chk("rj_rst.action", 32'(action), 32'd9);
    chk("rj_rst.busy", 32'(busy), 32'd0);
    chk("rj_rst.direction", 32'(direction), 32'd1);
    chk("rj_rst.hit", 32'(hit_pulse), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    key_right = 1;
    step("rw0", 10'd0, 10'd1, 1'b0, 1'b0);
    step("rw1", 10'd0, 10'd1, 1'b0, 1'b0);
    step("rw2", 10'd1, 10'd1, 1'b0, 1'b0);

    // frame_clk held high for 100 Clk: a single tick
    @(negedge Clk) frame_clk = 1'b1;
    repeat (100) @(negedge Clk);
    chk("hold.action", 32'(action), 32'd1);
    chk("hold.direction", 32'(direction), 32'd1);
    frame_clk = 1'b0;
    @(negedge Clk);
    step("hold_next", 10'd2, 10'd1, 1'b0, 1'b0);
    key_right = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
